cache_flush_seq: RTL and testbench

- Flush/clean sequencer for the 4-way, 256-bit-line cache (13-bit index, 14-bit tag).
- On request, takes ownership of the tag, valid, dirty and data arrays from the main cache FSM and walks every index.
- Writes each valid+dirty line back to main memory, then clears dirty bits, and optionally valid bits.
- Sits beside the main FSM and replaces its single-cycle INVAL_ALL with a writeback-correct flush.

---
 rtl/cache_flush_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_cache_flush_seq.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_flush_seq.sv
// Flush/clean sequencer: borrows the cache arrays from the main FSM, walks every set,
// writes back valid+dirty lines in ascending way order, then clears dirty (and optionally valid) bits.
module cache_flush_seq #(
    parameter int unsigned IDX_BITS  = 13,
    parameter int unsigned TAG_BITS  = 14,
    parameter int unsigned WAYS      = 4,
    parameter int unsigned LINE_BITS = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_req,
    input  logic                     flush_inval,
    output logic                     flush_busy,
    output logic                     flush_done,
    output logic                     own_req,
    input  logic                     own_gnt,
    output logic [IDX_BITS-1:0]      arr_idx,
    output logic                     arr_rd,
    input  logic [WAYS-1:0]          valid_in,
    input  logic [WAYS-1:0]          dirty_in,
    input  logic [WAYS*TAG_BITS-1:0] tag_in,
    output logic                     data_rd,
    output logic [1:0]               data_way,
    input  logic [LINE_BITS-1:0]     data_in,
    output logic                     vd_wr,
    output logic [WAYS-1:0]          valid_wd,
    output logic [WAYS-1:0]          dirty_wd,
    output logic                     mm_wr_req,
    output logic [31:0]              mm_wr_addr,
    output logic [LINE_BITS-1:0]     mm_wr_data,
    input  logic                     mm_wr_ack,
    output logic [IDX_BITS+2:0]      wb_count
);

    localparam int unsigned CNT_BITS  = IDX_BITS + 3;
    localparam int unsigned ADDR_BITS = 32;
    localparam int unsigned OFF_BITS  = 5;

    typedef enum logic [3:0] {
        IDLE,
        ARB,
        RD_IDX,
        CHK,
        RD_LINE,
        WB,
        CLR,
        NEXT,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic                  inval_q;
    logic                  inval_nxt;
    logic [WAYS-1:0]       pend;
    logic [WAYS-1:0]       pend_nxt;
    logic [WAYS-1:0]       valid_q;
    logic [WAYS-1:0]       valid_q_nxt;
    logic [TAG_BITS-1:0]   tag_q     [WAYS];
    logic [TAG_BITS-1:0]   tag_q_nxt [WAYS];
    logic [IDX_BITS-1:0]   idx_nxt;
    logic [CNT_BITS-1:0]   wb_count_nxt;
    logic [1:0]            data_way_nxt;
    logic [WAYS-1:0]       valid_wd_nxt;
    logic [WAYS-1:0]       dirty_wd_nxt;
    logic                  mm_wr_req_nxt;
    logic [ADDR_BITS-1:0]  mm_wr_addr_nxt;
    logic [LINE_BITS-1:0]  mm_wr_data_nxt;

    // Lowest pending way: ways are always serviced in ascending order.
    function automatic logic [1:0] low_way(input logic [WAYS-1:0] p);
        logic [1:0] w;
        w = 2'd0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (p[i]) begin
                w = 2'(i);
            end
        end
        return w;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        inval_nxt      = inval_q;
        pend_nxt       = pend;
        valid_q_nxt    = valid_q;
        tag_q_nxt      = tag_q;
        idx_nxt        = arr_idx;
        wb_count_nxt   = wb_count;
        mm_wr_req_nxt  = mm_wr_req;
        mm_wr_addr_nxt = mm_wr_addr;
        mm_wr_data_nxt = mm_wr_data;
        valid_wd_nxt   = valid_wd;
        dirty_wd_nxt   = dirty_wd;
        data_way_nxt   = data_way;

        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_nxt    = ARB;
                    inval_nxt    = flush_inval;
                    idx_nxt      = '0;
                    wb_count_nxt = '0;
                end
            end
            ARB: begin
                if (own_gnt) begin
                    state_nxt = RD_IDX;
                end
            end
            RD_IDX: begin
                state_nxt = CHK;
            end
            CHK: begin
                valid_q_nxt = valid_in;
                pend_nxt    = valid_in & dirty_in;
                for (int i = 0; i < int'(WAYS); i++) begin
                    tag_q_nxt[i] = tag_in[i*TAG_BITS +: TAG_BITS];
                end
                if (pend_nxt != '0) begin
                    state_nxt = RD_LINE;
                end else if (inval_q && (valid_in != '0)) begin
                    state_nxt = CLR;
                end else begin
                    state_nxt = NEXT;
                end
            end
            RD_LINE: begin
                state_nxt = WB;
            end
            WB: begin
                // First WB cycle captures the line; the request rises with stable addr/data.
                if (!mm_wr_req) begin
                    mm_wr_req_nxt  = 1'b1;
                    mm_wr_data_nxt = data_in;
                    mm_wr_addr_nxt = ADDR_BITS'({tag_q[data_way], arr_idx, OFF_BITS'(0)});
                end else if (mm_wr_ack) begin
                    mm_wr_req_nxt = 1'b0;
                    pend_nxt      = pend & ~(WAYS'(1) << data_way);
                    wb_count_nxt  = wb_count + CNT_BITS'(1);
                    state_nxt     = (pend_nxt != '0) ? RD_LINE : CLR;
                end
            end
            CLR: begin
                state_nxt = NEXT;
            end
            NEXT: begin
                idx_nxt   = arr_idx + IDX_BITS'(1);
                state_nxt = (&arr_idx) ? DONE : RD_IDX;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt == RD_LINE) begin
            data_way_nxt = low_way(pend_nxt);
        end
        if (state_nxt == CLR) begin
            valid_wd_nxt = inval_q ? '0 : valid_q_nxt;
            dirty_wd_nxt = '0;
        end
    end

    // Datapath and registered outputs; strobes are decoded from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inval_q    <= 1'b0;
            pend       <= '0;
            valid_q    <= '0;
            for (int i = 0; i < int'(WAYS); i++) begin
                tag_q[i] <= '0;
            end
            arr_idx    <= '0;
            wb_count   <= '0;
            flush_busy <= 1'b0;
            flush_done <= 1'b0;
            own_req    <= 1'b0;
            arr_rd     <= 1'b0;
            data_rd    <= 1'b0;
            data_way   <= 2'd0;
            vd_wr      <= 1'b0;
            valid_wd   <= '0;
            dirty_wd   <= '0;
            mm_wr_req  <= 1'b0;
            mm_wr_addr <= '0;
            mm_wr_data <= '0;
        end else begin
            inval_q    <= inval_nxt;
            pend       <= pend_nxt;
            valid_q    <= valid_q_nxt;
            tag_q      <= tag_q_nxt;
            arr_idx    <= idx_nxt;
            wb_count   <= wb_count_nxt;
            flush_busy <= (state_nxt != IDLE);
            own_req    <= (state_nxt != IDLE);
            flush_done <= (state_nxt == DONE);
            arr_rd     <= (state_nxt == RD_IDX);
            data_rd    <= (state_nxt == RD_LINE);
            vd_wr      <= (state_nxt == CLR);
            data_way   <= data_way_nxt;
            valid_wd   <= valid_wd_nxt;
            dirty_wd   <= dirty_wd_nxt;
            mm_wr_req  <= mm_wr_req_nxt;
            mm_wr_addr <= mm_wr_addr_nxt;
            mm_wr_data <= mm_wr_data_nxt;
        end
    end

endmodule

// File: tb/tb_cache_flush_seq.sv
// Bench for cache_flush_seq: a 4-set instance checked against a set-walk model,
// plus a full-size instance for the real address layout.
module tb_cache_flush_seq;

    localparam int unsigned IB = 2;
    localparam int unsigned TB = 25;
    localparam int unsigned LB = 256;
    localparam int unsigned LOGN = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // small instance
    logic            flush_req, flush_inval, flush_busy, flush_done, own_req;
    logic            own_gnt = 1'b0;
    logic [IB-1:0]   arr_idx;
    logic            arr_rd, data_rd, vd_wr, mm_wr_req, mm_wr_ack;
    logic [3:0]      valid_in, dirty_in, valid_wd, dirty_wd;
    logic [4*TB-1:0] tag_in;
    logic [1:0]      data_way;
    logic [LB-1:0]   data_in, mm_wr_data;
    logic [31:0]     mm_wr_addr;
    logic [IB+2:0]   wb_count;

    cache_flush_seq #(.IDX_BITS(IB), .TAG_BITS(TB), .WAYS(4), .LINE_BITS(LB)) u_dut (
        .clk(clk), .rst(rst), .flush_req(flush_req), .flush_inval(flush_inval),
        .flush_busy(flush_busy), .flush_done(flush_done), .own_req(own_req), .own_gnt(own_gnt),
        .arr_idx(arr_idx), .arr_rd(arr_rd), .valid_in(valid_in), .dirty_in(dirty_in),
        .tag_in(tag_in), .data_rd(data_rd), .data_way(data_way), .data_in(data_in),
        .vd_wr(vd_wr), .valid_wd(valid_wd), .dirty_wd(dirty_wd), .mm_wr_req(mm_wr_req),
        .mm_wr_addr(mm_wr_addr), .mm_wr_data(mm_wr_data), .mm_wr_ack(mm_wr_ack),
        .wb_count(wb_count)
    );

    // full-size instance
    logic          b_flush_req, b_flush_inval, b_busy, b_done, b_own_req;
    logic          b_gnt = 1'b0;
    logic [12:0]   b_arr_idx;
    logic          b_arr_rd, b_data_rd, b_vd_wr, b_req, b_ack;
    logic [3:0]    b_valid_in, b_dirty_in, b_valid_wd, b_dirty_wd;
    logic [55:0]   b_tag_in;
    logic [1:0]    b_data_way;
    logic [LB-1:0] b_data_in, b_wdata;
    logic [31:0]   b_addr;
    logic [15:0]   b_wb_count;

    cache_flush_seq #(.IDX_BITS(13), .TAG_BITS(14), .WAYS(4), .LINE_BITS(LB)) u_big (
        .clk(clk), .rst(rst), .flush_req(b_flush_req), .flush_inval(b_flush_inval),
        .flush_busy(b_busy), .flush_done(b_done), .own_req(b_own_req), .own_gnt(b_gnt),
        .arr_idx(b_arr_idx), .arr_rd(b_arr_rd), .valid_in(b_valid_in), .dirty_in(b_dirty_in),
        .tag_in(b_tag_in), .data_rd(b_data_rd), .data_way(b_data_way), .data_in(b_data_in),
        .vd_wr(b_vd_wr), .valid_wd(b_valid_wd), .dirty_wd(b_dirty_wd), .mm_wr_req(b_req),
        .mm_wr_addr(b_addr), .mm_wr_data(b_wdata), .mm_wr_ack(b_ack),
        .wb_count(b_wb_count)
    );

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    // cache contents seen by the small instance
    logic [3:0]    m_valid [4];
    logic [3:0]    m_dirty [4];
    logic [TB-1:0] m_tag   [4][4];
    logic [LB-1:0] m_data  [4][4];

    int unsigned ack_delay = 0;
    int unsigned gnt_delay = 0;
    int unsigned ack_cnt = 0;
    int unsigned gnt_cnt = 0;

    assign mm_wr_ack = mm_wr_req && (ack_cnt >= ack_delay);

    always @(posedge clk) begin
        ack_cnt <= (mm_wr_req && !mm_wr_ack) ? ack_cnt + 1 : 0;
        if (!own_req) begin
            gnt_cnt <= 0;
            own_gnt <= 1'b0;
        end else if (gnt_cnt >= gnt_delay) begin
            own_gnt <= 1'b1;
        end else begin
            gnt_cnt <= gnt_cnt + 1;
        end
        if (arr_rd) begin
            valid_in <= m_valid[arr_idx];
            dirty_in <= m_dirty[arr_idx];
            for (int w = 0; w < 4; w++) tag_in[w*TB +: TB] <= m_tag[arr_idx][w];
        end
        if (data_rd) data_in <= m_data[arr_idx][data_way];
    end

    // monitor: logs handshakes and protocol violations
    int unsigned done_cnt = 0, wb_n = 0, vd_n = 0, rd_n = 0, req_cyc = 0;
    int unsigned nogrant_err = 0, multi_err = 0, unstable_err = 0;
    logic [31:0]   wb_addr_log [LOGN];
    logic [LB-1:0] wb_data_log [LOGN];
    logic [IB-1:0] vd_idx_log  [LOGN];
    logic [3:0]    vd_v_log    [LOGN];
    logic [3:0]    vd_d_log    [LOGN];
    logic [IB-1:0] rd_idx_log  [LOGN];
    logic          prev_req = 1'b0;
    logic [31:0]   prev_addr = '0;
    logic [LB-1:0] prev_data = '0;

    always @(negedge clk) begin
        if ((arr_rd || data_rd || vd_wr) && !own_gnt) nogrant_err <= nogrant_err + 1;
        if ($countones({arr_rd, data_rd, vd_wr}) > 1) multi_err <= multi_err + 1;
        if (mm_wr_req && prev_req && (mm_wr_addr != prev_addr || mm_wr_data != prev_data))
            unstable_err <= unstable_err + 1;
        if (mm_wr_req) req_cyc <= req_cyc + 1;
        if (mm_wr_req && mm_wr_ack && wb_n < LOGN) begin
            wb_addr_log[wb_n] <= mm_wr_addr;
            wb_data_log[wb_n] <= mm_wr_data;
            wb_n <= wb_n + 1;
        end
        if (vd_wr && vd_n < LOGN) begin
            vd_idx_log[vd_n] <= arr_idx;
            vd_v_log[vd_n]   <= valid_wd;
            vd_d_log[vd_n]   <= dirty_wd;
            vd_n <= vd_n + 1;
        end
        if (arr_rd && rd_n < LOGN) begin
            rd_idx_log[rd_n] <= arr_idx;
            rd_n <= rd_n + 1;
        end
        if (flush_done) done_cnt <= done_cnt + 1;
        prev_req  <= mm_wr_req;
        prev_addr <= mm_wr_addr;
        prev_data <= mm_wr_data;
    end

    // full-size responder: only set 1 holds a line (way 2, valid+dirty)
    function automatic logic [LB-1:0] big_line(input logic [1:0] w);
        return {8{32'hC0DE_0000 | 32'(w)}};
    endfunction

    assign b_tag_in = {14'h3AAA, 14'h1234, 14'h0555, 14'h2222};
    assign b_ack    = b_req;

    int unsigned b_wb_n = 0, b_vd_n = 0, b_done_n = 0;
    logic [31:0]   b_addr0 = '0;
    logic [LB-1:0] b_data0 = '0;
    logic [3:0]    b_vwd = 4'hF, b_dwd = 4'hF;

    always @(posedge clk) begin
        b_gnt <= b_own_req;
        if (b_arr_rd) begin
            b_valid_in <= (b_arr_idx == 13'd1) ? 4'b0100 : 4'b0000;
            b_dirty_in <= (b_arr_idx == 13'd1) ? 4'b0100 : 4'b0000;
        end
        if (b_data_rd) b_data_in <= big_line(b_data_way);
    end

    always @(negedge clk) begin
        if (b_req && b_ack) begin
            if (b_wb_n == 0) begin
                b_addr0 <= b_addr;
                b_data0 <= b_wdata;
            end
            b_wb_n <= b_wb_n + 1;
        end
        if (b_vd_wr) begin
            b_vd_n <= b_vd_n + 1;
            b_vwd  <= b_valid_wd;
            b_dwd  <= b_dirty_wd;
        end
        if (b_done) b_done_n <= b_done_n + 1;
    end

    task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic load_idx(input int i, input logic [3:0] v, input logic [3:0] d);
        m_valid[i] = v;
        m_dirty[i] = d;
        for (int w = 0; w < 4; w++) begin
            m_tag[i][w]  = TB'({$urandom, 2'(w)});
            m_data[i][w] = rand_line();
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4; i++) load_idx(i, 4'b0, 4'b0);
    endtask

    task automatic run_flush(input logic inv, input int unsigned budget, input bit repulse);
        int unsigned d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        @(posedge clk); #1;
        flush_inval = inv;
        flush_req   = 1'b1;
        @(posedge clk); #1;
        flush_req   = 1'b0;
        flush_inval = ~inv;
        for (int c = 0; c < int'(budget); c++) begin
            if (repulse && c == 2) begin
                chk("busy in arb", {flush_busy, own_req, own_gnt, arr_rd}, 4'b1100);
            end
            flush_req = repulse && (c == 3 || c == 12);
            @(posedge clk); #1;
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        flush_req = 1'b0;
        chk("flush completes", LB'(seen), LB'(1));
    endtask

    // Expected writebacks and array writes derived directly from the cache contents.
    task automatic verify_flush(input string nm, input logic inv, input int unsigned wb_base,
                                input int unsigned vd_base, input int unsigned done_base);
        int unsigned e, v;
        logic [3:0]  pend;
        logic [31:0] ea;
        e = 0;
        v = 0;
        for (int i = 0; i < 4; i++) begin
            pend = m_valid[i] & m_dirty[i];
            for (int w = 0; w < 4; w++) begin
                if (pend[w]) begin
                    ea = (32'(m_tag[i][w]) << 7) | (32'(i) << 5);
                    if (wb_base + e < wb_n) begin
                        chk($sformatf("%s wb%0d addr", nm, e), LB'(wb_addr_log[wb_base+e]), LB'(ea));
                        chk($sformatf("%s wb%0d data", nm, e), wb_data_log[wb_base+e], m_data[i][w]);
                    end
                    e++;
                end
            end
            if (pend != 4'b0 || (inv && m_valid[i] != 4'b0)) begin
                if (vd_base + v < vd_n) begin
                    chk($sformatf("%s vd%0d idx", nm, v), LB'(vd_idx_log[vd_base+v]), LB'(i));
                    chk($sformatf("%s vd%0d valid", nm, v), LB'(vd_v_log[vd_base+v]),
                        LB'(inv ? 4'b0 : m_valid[i]));
                    chk($sformatf("%s vd%0d dirty", nm, v), LB'(vd_d_log[vd_base+v]), LB'(0));
                end
                v++;
            end
        end
        chk({nm, " writebacks"}, LB'(wb_n - wb_base), LB'(e));
        chk({nm, " wb_count"}, LB'(wb_count), LB'(e));
        chk({nm, " vd_wr count"}, LB'(vd_n - vd_base), LB'(v));
        chk({nm, " done pulses"}, LB'(done_cnt - done_base), LB'(1));
    endtask

    typedef struct {
        logic [1:0]  idx;
        logic [3:0]  valid;
        logic [3:0]  dirty;
        logic        inval;
        int unsigned ack_dly;
        int unsigned exp_wb;
        int unsigned exp_vd;
        logic [3:0]  exp_vwd;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int unsigned wb0, vd0, dn0, rq0, rd0;
        logic inv;
        bit seen;

        tbl[0] = '{2'd0, 4'b0000, 4'b0000, 1'b1, 0, 0, 0, 4'b0000};
        tbl[1] = '{2'd2, 4'b1011, 4'b0010, 1'b0, 1, 1, 1, 4'b1011};
        tbl[2] = '{2'd0, 4'b1111, 4'b1111, 1'b1, 3, 4, 1, 4'b0000};
        tbl[3] = '{2'd3, 4'b0110, 4'b0000, 1'b1, 0, 0, 1, 4'b0000};
        tbl[4] = '{2'd1, 4'b0101, 4'b0000, 1'b0, 0, 0, 0, 4'b0000};
        tbl[5] = '{2'd3, 4'b1001, 4'b1111, 1'b0, 0, 2, 1, 4'b1001};
        tbl[6] = '{2'd1, 4'b0100, 4'b0100, 1'b1, 2, 1, 1, 4'b0000};

        rst = 1'b1;
        flush_req = 1'b0;
        flush_inval = 1'b0;
        b_flush_req = 1'b0;
        b_flush_inval = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy/done/own", LB'({flush_busy, flush_done, own_req}), LB'(0));
        chk("reset strobes", LB'({arr_rd, data_rd, vd_wr, mm_wr_req}), LB'(0));
        chk("reset idx/wb_count", LB'({arr_idx, wb_count}), LB'(0));
        chk("reset addr", LB'(mm_wr_addr), LB'(0));
        rst = 1'b0;

        // directed single-set vectors
        for (int t = 0; t < 7; t++) begin
            clear_mem();
            load_idx(int'(tbl[t].idx), tbl[t].valid, tbl[t].dirty);
            ack_delay = tbl[t].ack_dly;
            gnt_delay = 0;
            wb0 = wb_n; vd0 = vd_n; dn0 = done_cnt; rq0 = req_cyc;
            run_flush(tbl[t].inval, 500, 1'b0);
            verify_flush($sformatf("vec%0d", t), tbl[t].inval, wb0, vd0, dn0);
            chk($sformatf("vec%0d wb_count", t), LB'(wb_count), LB'(tbl[t].exp_wb));
            chk($sformatf("vec%0d vd count", t), LB'(vd_n - vd0), LB'(tbl[t].exp_vd));
            if (tbl[t].exp_vd != 0 && vd_n > 0)
                chk($sformatf("vec%0d valid_wd", t), LB'(vd_v_log[vd_n-1]), LB'(tbl[t].exp_vwd));
            if (tbl[t].exp_wb == 0)
                chk($sformatf("vec%0d no req", t), LB'(req_cyc - rq0), LB'(0));
        end

        // randomized contents, ack and grant latency
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++) load_idx(i, 4'($urandom), 4'($urandom));
            inv = 1'($urandom);
            ack_delay = $urandom_range(0, 3);
            gnt_delay = $urandom_range(0, 3);
            wb0 = wb_n; vd0 = vd_n; dn0 = done_cnt;
            run_flush(inv, 1000, 1'b0);
            verify_flush($sformatf("rnd%0d", r), inv, wb0, vd0, dn0);
        end

        // slow grant, request re-pulsed while busy
        for (int i = 0; i < 4; i++) load_idx(i, 4'($urandom), 4'($urandom));
        ack_delay = 1;
        gnt_delay = 5;
        wb0 = wb_n; vd0 = vd_n; dn0 = done_cnt;
        run_flush(1'b1, 1000, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        verify_flush("gnt", 1'b1, wb0, vd0, dn0);
        chk("gnt idle after", LB'({flush_busy, own_req}), LB'(0));
        gnt_delay = 0;

        // asynchronous reset in the middle of a writeback
        clear_mem();
        load_idx(0, 4'hF, 4'hF);
        ack_delay = 20;
        @(posedge clk); #1;
        flush_inval = 1'b1;
        flush_req   = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (mm_wr_req) begin
                seen = 1'b1;
                break;
            end
        end
        chk("req before reset", LB'(seen), LB'(1));
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async reset req/own/busy", LB'({mm_wr_req, own_req, flush_busy}), LB'(0));
        chk("async reset wb_count", LB'(wb_count), LB'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        ack_delay = 0;
        for (int i = 0; i < 4; i++) load_idx(i, 4'($urandom), 4'($urandom));
        wb0 = wb_n; vd0 = vd_n; dn0 = done_cnt; rd0 = rd_n;
        run_flush(1'b0, 1000, 1'b0);
        verify_flush("post-reset", 1'b0, wb0, vd0, dn0);
        chk("post-reset reads", LB'(rd_n - rd0), LB'(4));
        if (rd_n > rd0) chk("post-reset first idx", LB'(rd_idx_log[rd0]), LB'(0));

        chk("no strobe without grant", LB'(nogrant_err), LB'(0));
        chk("single strobe", LB'(multi_err), LB'(0));
        chk("addr/data stable", LB'(unstable_err), LB'(0));

        // full-size instance: one dirty line at set 1, way 2
        @(posedge clk); #1;
        b_flush_inval = 1'b1;
        b_flush_req   = 1'b1;
        @(posedge clk); #1;
        b_flush_req   = 1'b0;
        b_flush_inval = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30000; c++) begin
            @(posedge clk); #1;
            if (b_done_n != 0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("big completes", LB'(seen), LB'(1));
        chk("big writes", LB'(b_wb_n), LB'(1));
        chk("big addr", LB'(b_addr0), LB'(32'h48D0_0020));
        chk("big data", b_data0, {8{32'hC0DE_0002}});
        chk("big vd_wr count", LB'(b_vd_n), LB'(1));
        chk("big vd data", LB'({b_vwd, b_dwd}), LB'(0));
        chk("big wb_count", LB'(b_wb_count), LB'(1));
        chk("big busy after", LB'({b_busy, b_own_req}), LB'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
